// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory port arbiter: FSM states, request
// owners and the bit positions used in the two-wide request/grant vectors.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    localparam int REQ_IF = 0;
    localparam int REQ_LS = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone request always wins, and on contention
// the requester not served last wins. Purely combinational.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // `last` is high when the LSU was the most recent winner
        if (req == 2'b11)
            gnt = last ? (2'b01 << REQ_IF) : (2'b01 << REQ_LS);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read memory port between the IFU and LSU: accept a
// request in IDLE, replay it in ACCESS, return the read data to its owner in RESP.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_rsp_valid,
    output logic [INST_WIDTH-1:0] if_rsp_inst,
    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic                  ls_wen,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic [DATA_WIDTH-1:0] ls_wmask,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_rdata,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e            state;
    owner_e                owner;
    owner_e                last_grant;
    logic                  lat_wen;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] lat_wmask;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       idle;
    logic       in_access;
    logic       in_resp;
    logic       hs_if;
    logic       hs_ls;

    assign req = {ls_valid, if_valid};

    rr_arb2 u_arb (
        .req  (req),
        .last (last_grant == OWNER_LS),
        .gnt  (gnt)
    );

    // Everything visible is masked by rst so nothing leaks out while reset is
    // held, even in the first cycle before the state registers have cleared.
    assign idle      = (state == ARB_IDLE)   && !rst;
    assign in_access = (state == ARB_ACCESS) && !rst;
    assign in_resp   = (state == ARB_RESP)   && !rst;

    assign if_ready = idle && gnt[REQ_IF];
    assign ls_ready = idle && gnt[REQ_LS];
    assign hs_if    = if_valid && if_ready;
    assign hs_ls    = ls_valid && ls_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_IF;
            last_grant <= OWNER_IF;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (hs_ls) begin
                        lat_addr   <= ls_addr;
                        lat_wen    <= ls_wen;
                        lat_wdata  <= ls_wdata;
                        lat_wmask  <= ls_wmask;
                        owner      <= OWNER_LS;
                        last_grant <= OWNER_LS;
                        state      <= ARB_ACCESS;
                    end else if (hs_if) begin
                        // fetches are reads: clear the write fields
                        lat_addr   <= if_addr;
                        lat_wen    <= 1'b0;
                        lat_wdata  <= '0;
                        lat_wmask  <= '0;
                        owner      <= OWNER_IF;
                        last_grant <= OWNER_IF;
                        state      <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: state <= ARB_RESP;
                ARB_RESP:   state <= ARB_IDLE;
                default:    state <= ARB_IDLE;
            endcase
        end
    end

    assign mem_rd_en = in_access && !lat_wen;
    assign mem_wr_en = in_access &&  lat_wen;
    assign mem_addr  = in_access ? lat_addr  : '0;
    assign mem_wdata = in_access ? lat_wdata : '0;
    assign mem_wmask = in_access ? lat_wmask : '0;

    assign if_rsp_valid = in_resp && (owner == OWNER_IF);
    assign ls_rsp_valid = in_resp && (owner == OWNER_LS);

    // The memory read is registered, so rdata is already valid in RESP and is
    // steered straight through rather than re-registered.
    always_comb begin
        if_rsp_inst = '0;
        if (if_rsp_valid)
            if_rsp_inst = lat_addr[2] ? mem_rdata[2*INST_WIDTH-1:INST_WIDTH]
                                      : mem_rdata[INST_WIDTH-1:0];
    end

    assign ls_rsp_rdata = (ls_rsp_valid && !lat_wen) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle registered-read memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, if_rsp_valid;
    logic [63:0] if_addr;
    logic [31:0] if_rsp_inst;
    logic        ls_valid, ls_ready, ls_wen, ls_rsp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_wmask, ls_rsp_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [63:0] mem_addr, mem_wdata, mem_wmask;
    logic [63:0] mem_rdata = 64'h0;
    logic [63:0] rd_value  = 64'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= rd_value;

    mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .INST_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_wen(ls_wen),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    task automatic test_reset();
        logic [5:0]  obs6;
        logic [1:0]  obs2;
        logic [64:0] obs65;
        rst = 1'b1; if_valid = 1'b1; ls_valid = 1'b1; ls_wen = 1'b0;
        ls_addr = 64'h8000_0100; rd_value = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            obs6 = {if_ready, ls_ready, if_rsp_valid, ls_rsp_valid, mem_rd_en, mem_wr_en};
            total++;
            if (obs6 !== 6'b0) begin
                bad++; $display("FAIL reset_quiet[%0d] got=%b want=000000", i, obs6);
            end
        end
        @(negedge clk); rst = 1'b0; #1;
        obs2 = {if_ready, ls_ready};
        total++;
        if (obs2 !== 2'b01) begin
            bad++; $display("FAIL reset_first_grant got=%b want=01", obs2);
        end
        @(negedge clk); if_valid = 1'b0; ls_valid = 1'b0; #1;
        obs65 = {mem_rd_en, mem_addr};
        total++;
        if (obs65 !== {1'b1, 64'h8000_0100}) begin
            bad++; $display("FAIL reset_ls_read_access got=%h want=%h", obs65, {1'b1, 64'h8000_0100});
        end
        #0;
        @(negedge clk); #1;
        obs65 = {ls_rsp_valid, ls_rsp_rdata};
        total++;
        if (obs65 !== {1'b1, 64'hAAAA_BBBB_CCCC_DDDD}) begin
            bad++; $display("FAIL reset_ls_read_rsp got=%h want=%h", obs65, {1'b1, 64'hAAAA_BBBB_CCCC_DDDD});
        end
    endtask

    task automatic test_if_fetch(input logic [63:0] addr, input logic [63:0] rdval,
                                 input logic [31:0] inst);
        logic [65:0] obs66;
        logic [33:0] obs34;
        @(negedge clk); if_valid = 1'b1; if_addr = addr; rd_value = rdval; #1;
        total++;
        if (if_ready !== 1'b1) begin
            bad++; $display("FAIL fetch_ready addr=%h got=%b want=1", addr, if_ready);
        end
        @(negedge clk); if_valid = 1'b0; #1;
        obs66 = {mem_rd_en, mem_wr_en, mem_addr};
        total++;
        if (obs66 !== {2'b10, addr}) begin
            bad++; $display("FAIL fetch_access got=%h want=%h", obs66, {2'b10, addr});
        end
        @(negedge clk); #1;
        obs34 = {if_rsp_valid, ls_rsp_valid, if_rsp_inst};
        total++;
        if (obs34 !== {2'b10, inst}) begin
            bad++; $display("FAIL fetch_rsp got=%h want=%h", obs34, {2'b10, inst});
        end
    endtask

    task automatic test_ls_write();
        logic [193:0] obs194;
        logic [65:0]  obs66;
        logic [2:0]   obs3;
        @(negedge clk);
        ls_valid = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_0010;
        ls_wdata = 64'hDEAD_BEEF_0000_0001; ls_wmask = 64'hFFFF_FFFF_0000_0000; #1;
        total++;
        if (ls_ready !== 1'b1) begin
            bad++; $display("FAIL write_ready got=%b want=1", ls_ready);
        end
        @(negedge clk); ls_valid = 1'b0; #1;
        obs194 = {mem_wr_en, mem_rd_en, mem_addr, mem_wdata, mem_wmask};
        total++;
        if (obs194 !== {2'b10, 64'h8000_0010, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_0000_0000}) begin
            bad++; $display("FAIL write_access got=%h want=%h", obs194,
                {2'b10, 64'h8000_0010, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_0000_0000});
        end
        @(negedge clk); #1;
        obs66 = {ls_rsp_valid, if_rsp_valid, ls_rsp_rdata};
        total++;
        if (obs66 !== {2'b10, 64'h0}) begin
            bad++; $display("FAIL write_rsp got=%h want=%h", obs66, {2'b10, 64'h0});
        end
        @(negedge clk); #1;
        obs3 = {mem_wr_en, ls_rsp_valid, if_rsp_valid};
        total++;
        if (obs3 !== 3'b000) begin
            bad++; $display("FAIL write_single_pulse got=%b want=000", obs3);
        end
    endtask

    task automatic test_contention();
        logic [1:0] obs2, exp2;
        logic       both_rsp = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if_valid = 1'b1; if_addr = 64'h8000_0000;
                ls_valid = 1'b1; ls_wen = 1'b0; ls_addr = 64'h8000_0200;
            end
            #1;
            obs2 = {if_ready, ls_ready};
            if (i % 3 != 0)           exp2 = 2'b00;
            else if ((i / 3) % 2 == 0) exp2 = 2'b01;
            else                       exp2 = 2'b10;
            if (if_rsp_valid && ls_rsp_valid) both_rsp = 1'b1;
            total++;
            if (obs2 !== exp2) begin
                bad++; $display("FAIL contention_grant[%0d] got=%b want=%b", i, obs2, exp2);
            end
        end
        @(negedge clk); if_valid = 1'b0; ls_valid = 1'b0;
        total++;
        if (both_rsp !== 1'b0) begin
            bad++; $display("FAIL contention_dual_rsp got=%b want=0", both_rsp);
        end
    endtask

    task automatic test_withdrawal();
        logic [1:0] obs2;
        logic       spurious = 1'b0;
        @(negedge clk); if_valid = 1'b1; if_addr = 64'h8000_0008; #1;
        obs2 = {if_ready, ls_ready};
        total++;
        if (obs2 !== 2'b10) begin
            bad++; $display("FAIL withdraw_if_grant got=%b want=10", obs2);
        end
        @(negedge clk); if_valid = 1'b0; ls_valid = 1'b1; ls_wen = 1'b1; #1;
        total++;
        if (ls_ready !== 1'b0) begin
            bad++; $display("FAIL withdraw_busy_ready got=%b want=0", ls_ready);
        end
        @(negedge clk); ls_valid = 1'b0; #1;
        total++;
        if (if_rsp_valid !== 1'b1) begin
            bad++; $display("FAIL withdraw_if_rsp got=%b want=1", if_rsp_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (mem_rd_en || mem_wr_en || ls_rsp_valid || if_rsp_valid || ls_ready) spurious = 1'b1;
        end
        total++;
        if (spurious !== 1'b0) begin
            bad++; $display("FAIL withdraw_no_side_effect got=%b want=0", spurious);
        end
    endtask

    task automatic test_reset_access();
        logic [1:0] obs2;
        @(negedge clk);
        ls_valid = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_0040;
        ls_wdata = 64'h1234_5678_9ABC_DEF0; ls_wmask = '1; #1;
        total++;
        if (ls_ready !== 1'b1) begin
            bad++; $display("FAIL rstacc_ready got=%b want=1", ls_ready);
        end
        @(negedge clk); ls_valid = 1'b0; rst = 1'b1; #1;
        obs2 = {mem_wr_en, mem_rd_en};
        total++;
        if (obs2 !== 2'b00) begin
            bad++; $display("FAIL rstacc_no_write got=%b want=00", obs2);
        end
        @(negedge clk); rst = 1'b0; if_valid = 1'b1; if_addr = 64'h8000_0004; #1;
        obs2 = {ls_rsp_valid, if_rsp_valid};
        total++;
        if (obs2 !== 2'b00) begin
            bad++; $display("FAIL rstacc_no_rsp got=%b want=00", obs2);
        end
        total++;
        if (if_ready !== 1'b1) begin
            bad++; $display("FAIL rstacc_idle got=%b want=1", if_ready);
        end
        @(negedge clk); if_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_addr = '0;
        ls_valid = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        test_reset();
        test_if_fetch(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
        test_if_fetch(64'h8000_0000, 64'h5555_6666_7777_8888, 32'h7777_8888);
        test_ls_write();
        test_contention();
        test_withdrawal();
        test_reset_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
